// File: rtl/core_pkg.sv
// Shared core constants and elaboration-time helpers.
package core_pkg;

   localparam int unsigned CORE_WIDTH = 32;

   // Smallest b with 2**b >= value; returns 0 for value <= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned b = 0; b < 32; b++) begin
         if ((64'd1 << b) < 64'(value)) result = b + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: fixed priority (lowest index) or round-robin starting at ptr.
module rr_arbiter
   import core_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned SEL_W = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             rr_en,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      int unsigned start;
      int unsigned idx;
      logic [SEL_W-1:0] sel;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      start   = rr_en ? 32'(ptr) : 32'd0;
      // Candidate order start, start+1, ... wrapped modulo N; first requester wins.
      for (int unsigned k = 0; k < N; k++) begin
         idx = start + k;
         if (idx >= N) idx = idx - N;
         sel = SEL_W'(idx);
         if (!gnt_any && req[sel]) begin
            gnt[sel] = 1'b1;
            gnt_idx  = sel;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input registered arbitrating mux with valid/ready on every input and the output.
module mux_arb_reg
   import core_pkg::*;
#(
   parameter int unsigned WIDTH = CORE_WIDTH,
   parameter int unsigned N     = 4,
   localparam int unsigned SEL_W = (N > 1) ? clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               rr_en,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

   logic [WIDTH-1:0] in_words [N];
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             load;
   logic             xfer;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign in_words[i] = in_data[i*WIDTH +: WIDTH];
   end

   rr_arbiter #(.N(N)) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .rr_en   (rr_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      load        = !out_valid_q || out_ready;
      xfer        = rst_n && load && gnt_any;
      // gnt is only ever set on a requesting channel, so this never readies an idle producer.
      in_ready    = xfer ? gnt : '0;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = in_words[gnt_idx];
         out_src_d   = gnt_idx;
         out_valid_d = 1'b1;
         ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: 4-channel DUT against a scoreboard model, 3-channel DUT for wrap cases.
module tb_mux_arb_reg;

   logic         clk;
   logic         rst_n;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic         rr_en;
   logic [31:0]  out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic         rr_en3;
   logic [31:0]  out_data3;
   logic [1:0]   out_src3;
   logic         out_valid3;
   logic         out_ready3;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
   } word_t;

   word_t sb[$];
   bit    m_valid;
   int    m_ptr;
   int    checks;
   int    errors;

   mux_arb_reg #(.WIDTH(32), .N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rr_en     (rr_en),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mux_arb_reg #(.WIDTH(32), .N(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .rr_en     (rr_en3),
      .out_data  (out_data3),
      .out_src   (out_src3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mgrant(input logic [3:0] v, input int p, input bit rr, input int n);
      for (int k = 0; k < n; k++) begin
         int i;
         i = rr ? (p + k) % n : k;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One clock of the 4-channel DUT: check pre-edge state, advance model, cross the edge.
   task automatic cyc();
      int         g;
      bit         load;
      logic [3:0] er;
      #1;
      load = !m_valid || out_ready;
      g    = mgrant(in_valid, m_ptr, rr_en, 4);
      er   = '0;
      if (rst_n && load && g >= 0) er[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(er));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed=word expected=empty");
         end else begin
            check("out_data", 64'(out_data), 64'(sb[0].data));
            check("out_src", 64'(out_src), 64'(sb[0].src));
         end
      end
      if (!rst_n) begin
         sb.delete();
         m_valid = 1'b0;
         m_ptr   = 0;
      end else begin
         if (m_valid && out_ready) void'(sb.pop_front());
         if (load) begin
            if (g >= 0) begin
               word_t w;
               w.src  = 2'(g);
               w.data = in_data[g*32 +: 32];
               sb.push_back(w);
               m_valid = 1'b1;
               m_ptr   = (g + 1) % 4;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic edge3();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int rr_seq [6];
      rr_seq = '{0, 1, 2, 3, 0, 1};
      checks = 0;
      errors = 0;
      rst_n = 1'b0; in_data = '0; in_valid = '0; rr_en = 1'b0; out_ready = 1'b0;
      in_data3 = '0; in_valid3 = '0; rr_en3 = 1'b0; out_ready3 = 1'b0;
      m_valid = 1'b0; m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while a word is held and every channel requests
      in_data[31:0] = 32'hA5A5_0000; in_valid = 4'b0001;
      cyc();
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0; in_valid = 4'b1111;
      cyc();
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_src", 64'(out_src), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1; in_valid = '0;

      // Fixed priority: ch1 beats ch3 until ch1 withdraws
      rr_en = 1'b0; out_ready = 1'b1;
      in_data[63:32] = 32'h1111_1111; in_data[127:96] = 32'h3333_3333;
      in_valid = 4'b1010;
      #1 check("fp_in_ready", 64'(in_ready), 64'b0010);
      cyc();
      check("fp_first_src", 64'(out_src), 64'd1);
      check("fp_first_data", 64'(out_data), 64'h1111_1111);
      cyc();
      check("fp_repeat_src", 64'(out_src), 64'd1);
      in_valid = 4'b1000;
      cyc();
      check("fp_second_src", 64'(out_src), 64'd3);
      check("fp_second_data", 64'(out_data), 64'h3333_3333);

      // Round-robin with all channels requesting: 0,1,2,3,0,1, no bubbles
      rr_en = 1'b1; in_valid = 4'b1111;
      in_data = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
      for (int i = 0; i < 6; i++) begin
         cyc();
         check("rr_src", 64'(out_src), 64'(rr_seq[i]));
         check("rr_valid", 64'(out_valid), 64'd1);
      end

      // Backpressure: held word stays put for 3 cycles, then ch2 goes through
      out_ready = 1'b0; in_valid = 4'b0100; in_data[95:64] = 32'h2222_2222;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp_src_stable", 64'(out_src), 64'd1);
         check("bp_data_stable", 64'(out_data), 64'hB1B1_0001);
      end
      out_ready = 1'b1;
      cyc();
      check("bp_release_src", 64'(out_src), 64'd2);
      check("bp_release_data", 64'(out_data), 64'h2222_2222);

      // Drain: out_valid falls one cycle after the last word
      in_valid = '0;
      cyc();
      check("drain_valid", 64'(out_valid), 64'd0);
      cyc();

      // Reset mid-operation drops a held word and returns ptr to 0
      out_ready = 1'b0; in_valid = 4'b0001; in_data[31:0] = 32'h0BAD_F00D;
      cyc();
      rst_n = 1'b0;
      cyc();
      check("midrst_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; rr_en = 1'b1;
      cyc();
      check("midrst_next_src", 64'(out_src), 64'd0);
      in_valid = '0;
      cyc();

      // Pseudo-random traffic against the model
      for (int i = 0; i < 40; i++) begin
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = 1'($urandom_range(0, 1));
         rr_en     = 1'($urandom_range(0, 1));
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      in_valid = '0; out_ready = 1'b1;
      cyc();

      // N=3: wrap from ptr=2 to ch0, then skip ch0 from ptr=1
      rr_en3 = 1'b1; out_ready3 = 1'b1;
      in_data3 = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
      in_valid3 = 3'b010;
      #1 check("n3_first_ready", 64'(in_ready3), 64'b010);
      edge3();
      check("n3_first_src", 64'(out_src3), 64'd1);
      in_valid3 = 3'b001;
      #1 check("n3_wrap_ready", 64'(in_ready3), 64'b001);
      edge3();
      check("n3_wrap_src", 64'(out_src3), 64'd0);
      check("n3_wrap_data", 64'(out_data3), 64'h0000_0C00);
      in_valid3 = 3'b101;
      #1 check("n3_skip_ready", 64'(in_ready3), 64'b100);
      edge3();
      check("n3_skip_src", 64'(out_src3), 64'd2);
      check("n3_skip_data", 64'(out_data3), 64'h0000_0C02);
      in_valid3 = 3'b101;
      #1 check("n3_after_last_ready", 64'(in_ready3), 64'b001);
      edge3();
      in_valid3 = '0;
      edge3();
      check("n3_drain_valid", 64'(out_valid3), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised successor to the core's 2:1 datapath select: an N-input, WIDTH-bit registered arbitrating mux with valid/ready handshakes on every input and on the output.
- Shares one downstream consumer among several producers, e.g. an I-fetch / load-store / debug port feeding a single memory request bus.
- Selection comes from an internal arbiter, either fixed-priority or round-robin, not from a select line.
- Latency is one register stage, with full throughput of one word per cycle.

Parameters:
- WIDTH, 32, data width in bits.
- N, 4, number of input channels (N >= 1).
- SEL_W, derived: max(1, clog2(N)), width of the source index. Not overridable.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- in_data, input, N*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N, per-channel request.
- in_ready, output, N, per-channel accept; one-hot or zero.
- rr_en, input, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- out_data, output, WIDTH, registered selected word.
- out_src, output, SEL_W, index of the channel that supplied out_data.
- out_valid, output, 1, out_data/out_src hold a word.
- out_ready, input, 1, consumer accepts the word this cycle.

Behaviour:
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0.
  - A word held at reset is dropped; no transfer is counted that cycle.
  - in_ready is forced to 0 while rst_n=0.
- load = !out_valid || out_ready (combinational).
- Grant g (combinational):
  - rr_en=0: lowest i with in_valid[i]=1.
  - rr_en=1: first i with in_valid[i]=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with wrap-around modulo N. This stays correct for non-power-of-2 N.
- in_ready[g] = load && in_valid[g]; every other in_ready bit = 0. No ready is asserted to a non-requesting channel.
- Input transfer on channel g occurs when in_valid[g] && in_ready[g].
- On the clock edge, when rst_n=1:
  - Transfer: out_data <= in_data[g]; out_src <= g; out_valid <= 1; ptr <= (g == N-1) ? 0 : g+1.
  - load=1 and no in_valid: out_valid <= 0; out_data and out_src hold their values.
  - load=0 (stall): all registers hold and all in_ready are 0.
- ptr updates on every transfer in both modes, so switching rr_en mid-stream is legal and takes effect the next cycle.
- Simultaneous output accept and input transfer in one cycle is allowed, giving back-to-back words at 1/cycle.
- Latency: a word accepted at edge k is visible on out_* after edge k and is consumed at the first edge where out_ready=1.
- in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- A producer must hold in_valid and in_data stable until its transfer. The block does not latch requests, so a withdrawn request simply loses arbitration.
- N=1: in_ready[0] = load && in_valid[0]; out_src is constant 0.
- Width rules: no arithmetic on the data path. The ptr increment is SEL_W bits with explicit wrap at N-1.

Decomposition:
- Shared package (core_pkg): the default WIDTH constant 32, and a clog2 function used for SEL_W.
- One natural sub-module, rr_arbiter: parameter N; inputs req[N], ptr, rr_en; output one-hot gnt[N] plus encoded index.
- mux_arb_reg holds the output register, the ptr register and the handshake logic.

Test Plan:
- Reset: drive rst_n=0 with in_valid=4'b1111 and out_valid previously 1 -> after the edge out_valid=0, out_data=0, out_src=0, in_ready=4'b0000; then release reset.
- Fixed priority: rr_en=0, in_valid=4'b1010, data ch1=0x11111111, ch3=0x33333333, out_ready=1 -> in_ready=4'b0010, next cycle out_data=0x11111111, out_src=1; ch3 is served only after ch1 drops valid.
- Round-robin fairness: rr_en=1, all four valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle with no bubbles.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with ch2 valid -> in_ready=0, out_data/out_src stable for all 3 cycles; on the first cycle out_ready=1, ch2 is transferred and appears on the next cycle.
- Wrap and skip: N=3 build, rr_en=1, ptr=2 after a ch1 grant, in_valid=3'b001 -> grant ch0 (wrap), ptr becomes 1; then in_valid=3'b100 -> grant ch2.
- Drain and reset mid-operation: stop all in_valid with out_ready=1 -> out_valid falls to 0 one cycle after the last word. Assert rst_n=0 while a word is held and out_ready=0 -> the word is dropped, ptr=0, and the next grant with all valid and rr_en=1 is ch0.
